// File: rtl/imm_extend_pipe_if.sv
// Bundle of the decode-side and execute-side valid/ready streams of imm_extend_pipe.
//   master : producer/consumer environment (drives in_* payload and out_ready)
//   slave  : the immediate pipeline (drives in_ready and out_* results)
// Signals:
//   in_valid/in_ready        input handshake
//   in_instr[23:0]           Instr[23:0]
//   in_immsrc[2:0]           immediate type select
//   in_cflag                 current CPSR C
//   in_tag[TAG_W-1:0]        opaque sideband
//   out_valid/out_ready      output handshake
//   out_imm[OUT_W-1:0]       extended immediate
//   out_carry                shifter carry-out
//   out_tag[TAG_W-1:0]       sideband aligned with out_imm
//   out_err, err_sticky      only with IMM_ERR_EN defined
interface imm_extend_pipe_if #(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [23:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic             in_cflag;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_carry;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_ERR_EN
  logic             out_err;
  logic             err_sticky;
`endif

  modport master (
    output in_valid, in_instr, in_immsrc, in_cflag, in_tag, out_ready,
`ifdef IMM_ERR_EN
    input  out_err, err_sticky,
`endif
    input  in_ready, out_valid, out_imm, out_carry, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_immsrc, in_cflag, in_tag, out_ready,
`ifdef IMM_ERR_EN
    output out_err, err_sticky,
`endif
    output in_ready, out_valid, out_imm, out_carry, out_tag
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined, elastic ARMv4 immediate generator. Stage 1 decodes Instr[23:0] per ImmSrc into an
// OUT_W-bit immediate plus shifter carry-out; remaining stages are plain elastic registers.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous reset, active-low
//   bus    : imm_extend_pipe_if.slave (input stream in_*, output stream out_*)
// Optional feature macro: IMM_ERR_EN adds out_err (per-beat illegal ImmSrc flag) and
// err_sticky (set on any accepted illegal beat, cleared only by reset).
module imm_extend_pipe #(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2,
  parameter int unsigned TAG_W    = 4
) (
  input logic           clk,
  input logic           reset,
  imm_extend_pipe_if.slave bus
);

  localparam int unsigned Last = STAGES - 1;

  // ---------------- stage-1 decode ----------------
  logic [OUT_W-1:0] imm_d;
  logic             carry_d;
  logic             err_d;
  logic [31:0]      rot_src;
  logic [31:0]      rot_res;
  logic [5:0]       rot_amt;
  logic [OUT_W-1:0] imm12_z;

  always_comb begin
    rot_src = 32'(bus.in_instr[7:0]);
    rot_amt = {1'b0, bus.in_instr[11:8], 1'b0};
    // A shift by 32 yields 0, so rot_amt == 0 degenerates cleanly to rot_src.
    rot_res = (rot_src >> rot_amt) | (rot_src << (6'd32 - rot_amt));
    imm12_z = OUT_W'(bus.in_instr[11:0]);
    imm_d   = '0;
    carry_d = bus.in_cflag;
    err_d   = 1'b0;
    case (bus.in_immsrc)
      3'b000: imm_d = OUT_W'(bus.in_instr[7:0]);
      3'b001: imm_d = imm12_z;
      3'b010: imm_d = OUT_W'($signed(bus.in_instr)) << BR_SHIFT;
      3'b011: begin
        imm_d = OUT_W'(rot_res);
        if (bus.in_instr[11:8] != 4'd0) carry_d = rot_res[31];
      end
      3'b100: imm_d = OUT_W'({bus.in_instr[11:8], bus.in_instr[3:0]});
      3'b101: imm_d = bus.in_instr[23] ? imm12_z : (~imm12_z + OUT_W'(1));
      default: err_d = 1'b1;
    endcase
  end

  // ---------------- elastic pipeline ----------------
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] err_q;
  logic [OUT_W-1:0]  imm_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [STAGES-1:0] src_err;
  logic [OUT_W-1:0]  src_imm [STAGES];
  logic [TAG_W-1:0]  src_tag [STAGES];
  logic              accept;
  logic              all_full;

  // Stage i can load when the consumer is ready or any stage from i to the output is empty;
  // this closed form avoids a combinational ready chain through a single vector.
  always_comb begin
    all_full = 1'b1;
    load     = '0;
    for (int i = Last; i >= 0; i--) begin
      all_full = all_full & valid_q[i];
      load[i]  = bus.out_ready | ~all_full;
    end
  end

  assign bus.in_ready = load[0] & reset;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    src_valid[0] = accept;
    src_carry[0] = carry_d;
    src_err[0]   = err_d;
    src_imm[0]   = imm_d;
    src_tag[0]   = bus.in_tag;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_carry[i] = carry_q[i-1];
      src_err[i]   = err_q[i-1];
      src_imm[i]   = imm_q[i-1];
      src_tag[i]   = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      carry_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          valid_q[i] <= src_valid[i];
          // Payload only updates on a real beat so idle outputs stay quiet.
          if (src_valid[i]) begin
            carry_q[i] <= src_carry[i];
            err_q[i]   <= src_err[i];
            imm_q[i]   <= src_imm[i];
            tag_q[i]   <= src_tag[i];
          end
        end
      end
    end
  end

  assign bus.out_valid = valid_q[Last];
  assign bus.out_imm   = imm_q[Last];
  assign bus.out_carry = carry_q[Last];
  assign bus.out_tag   = tag_q[Last];

`ifdef IMM_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_sticky_q <= 1'b0;
    end else if (accept && err_d) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign bus.out_err    = err_q[Last];
  assign bus.err_sticky = err_sticky_q;
`else
  logic unused_err;
  assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (STAGES=2, OUT_W=32): table of directed decode vectors,
// then hand-written backpressure and mid-stream reset sequences.
module tb_imm_extend_pipe;
  localparam int unsigned STAGES = 2;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned TAG_W  = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imm_extend_pipe_if #(.OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_pipe #(
    .STAGES  (STAGES),
    .OUT_W   (OUT_W),
    .BR_SHIFT(2),
    .TAG_W   (TAG_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] instr;
    logic [2:0]  immsrc;
    logic        cflag;
    logic [31:0] exp_imm;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_immsrc = '0;
    bus.in_cflag  = 1'b0;
    bus.in_tag    = '0;
  endtask

  initial begin
    int lat;
    int stale;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{24'h0004FF, 3'b011, 1'b0, 32'hFF000000, 1'b1};
    vecs[1]  = '{24'h0000A5, 3'b011, 1'b1, 32'h000000A5, 1'b1};
    vecs[2]  = '{24'hFFFFFE, 3'b010, 1'b0, 32'hFFFFFFF8, 1'b0};
    vecs[3]  = '{24'h000004, 3'b101, 1'b1, 32'hFFFFFFFC, 1'b1};
    vecs[4]  = '{24'h800004, 3'b101, 1'b0, 32'h00000004, 1'b0};
    vecs[5]  = '{24'h123456, 3'b000, 1'b0, 32'h00000056, 1'b0};
    vecs[6]  = '{24'h123456, 3'b001, 1'b1, 32'h00000456, 1'b1};
    vecs[7]  = '{24'h000A5C, 3'b100, 1'b0, 32'h000000AC, 1'b0};
    vecs[8]  = '{24'hFFFFFF, 3'b110, 1'b1, 32'h00000000, 1'b1};
    vecs[9]  = '{24'h00FFFF, 3'b111, 1'b0, 32'h00000000, 1'b0};
    vecs[10] = '{24'h0001FF, 3'b011, 1'b0, 32'hC000003F, 1'b1};
    vecs[11] = '{24'h000202, 3'b011, 1'b1, 32'h20000000, 1'b0};
    vecs[12] = '{24'h000001, 3'b010, 1'b1, 32'h00000004, 1'b1};
    vecs[13] = '{24'h800000, 3'b101, 1'b0, 32'h00000000, 1'b0};
    vecs[14] = '{24'h000000, 3'b101, 1'b0, 32'h00000000, 1'b0};
    vecs[15] = '{24'h7FFFFF, 3'b010, 1'b0, 32'h01FFFFFC, 1'b0};

    // ---- reset state ----
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef IMM_ERR_EN
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
`endif
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // ---- table-driven decode, one beat at a time ----
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_instr  = vecs[i].instr;
      bus.in_immsrc = vecs[i].immsrc;
      bus.in_cflag  = vecs[i].cflag;
      bus.in_tag    = TAG_W'(i);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      idle_inputs();
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(STAGES));
      chk($sformatf("v%0d_imm", i), 64'(bus.out_imm), 64'(vecs[i].exp_imm));
      chk($sformatf("v%0d_carry", i), 64'(bus.out_carry), 64'(vecs[i].exp_carry));
      chk($sformatf("v%0d_tag", i), 64'(bus.out_tag), 64'(i));
`ifdef IMM_ERR_EN
      chk($sformatf("v%0d_err", i), 64'(bus.out_err), 64'(vecs[i].immsrc[2:1] == 2'b11));
`endif
    end
`ifdef IMM_ERR_EN
    chk("err_sticky_set", 64'(bus.err_sticky), 64'd1);
`endif
    @(negedge clk);
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);

    // ---- backpressure: fill with tags 1,2, then stall ----
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      bus.in_valid  = 1'b1;
      bus.in_immsrc = 3'b000;
      bus.in_instr  = 24'(t * 'h11);
      bus.in_tag    = TAG_W'(t);
      #1;
      chk($sformatf("bp_push%0d_ready", t), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
    end
    bus.in_instr = 24'h33;
    bus.in_tag   = TAG_W'(3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_stall_tag", 64'(bus.out_tag), 64'd1);
      chk("bp_stall_imm", 64'(bus.out_imm), 64'h11);
      @(negedge clk);
    end
    // Release: same-cycle pop/push, then drain 1,2,3,4 one per cycle.
    bus.out_ready = 1'b1;
    #1;
    chk("bp_poppush_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_out1_tag", 64'(bus.out_tag), 64'd1);
    @(negedge clk);
    bus.in_instr = 24'h44;
    bus.in_tag   = TAG_W'(4);
    #1;
    chk("bp_push4_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_out2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_out2_tag", 64'(bus.out_tag), 64'd2);
    @(negedge clk);
    idle_inputs();
    chk("bp_out3_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_out3_tag", 64'(bus.out_tag), 64'd3);
    chk("bp_out3_imm", 64'(bus.out_imm), 64'h33);
    @(negedge clk);
    chk("bp_out4_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_out4_tag", 64'(bus.out_tag), 64'd4);
    chk("bp_out4_imm", 64'(bus.out_imm), 64'h44);
    @(negedge clk);
    chk("bp_empty_valid", 64'(bus.out_valid), 64'd0);

    // ---- reset mid-stream with two beats in flight ----
    bus.out_ready = 1'b0;
    for (int t = 5; t <= 6; t++) begin
      bus.in_valid  = 1'b1;
      bus.in_immsrc = 3'b001;
      bus.in_instr  = 24'hABC;
      bus.in_tag    = TAG_W'(t);
      @(negedge clk);
    end
    idle_inputs();
    chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_imm", 64'(bus.out_imm), 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
`ifdef IMM_ERR_EN
    chk("mid_rst_sticky", 64'(bus.err_sticky), 64'd0);
`endif
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
